// File: rtl/dmem_wr_arbiter_if.sv
// Burst-writer side and DMEM write-port side of the write arbiter.
// master drives requests/beats, slave is the arbiter.
interface dmem_wr_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 256
);
  logic              iREQ0;
  logic              iREQ1;
  logic              iVALID0;
  logic              iVALID1;
  logic              iLAST0;
  logic              iLAST1;
  logic [ADDR_W-1:0] iADDR0;
  logic [ADDR_W-1:0] iADDR1;
  logic [DATA_W-1:0] iDATA0;
  logic [DATA_W-1:0] iDATA1;
  logic              oGNT0;
  logic              oGNT1;
  logic              oREADY0;
  logic              oREADY1;
  logic              oWREN;
  logic [ADDR_W-1:0] oWRADDR;
  logic [DATA_W-1:0] oWRDATA;
  logic              oBUSY;
  logic              oERR_TIMEOUT;
  logic              oERR_OVERRUN;

  modport slave (
    input  iREQ0, iREQ1, iVALID0, iVALID1,
    input  iLAST0, iLAST1, iADDR0, iADDR1,
    input  iDATA0, iDATA1,
    output oGNT0, oGNT1, oREADY0, oREADY1,
    output oWREN, oWRADDR, oWRDATA, oBUSY,
    output oERR_TIMEOUT, oERR_OVERRUN
  );

  modport master (
    output iREQ0, iREQ1, iVALID0, iVALID1,
    output iLAST0, iLAST1, iADDR0, iADDR1,
    output iDATA0, iDATA1,
    input  oGNT0, oGNT1, oREADY0, oREADY1,
    input  oWREN, oWRADDR, oWRDATA, oBUSY,
    input  oERR_TIMEOUT, oERR_OVERRUN
  );
endinterface

// File: rtl/dmem_wr_arbiter.sv
// Round-robin whole-burst arbiter for the shared DMEM write port.
// Camera capture is requester 0, SPART loader is requester 1.
module dmem_wr_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 25,
  parameter int TIMEOUT   = 1023
) (
  input logic              iCLK,
  input logic              iRST,
  dmem_wr_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              prio;
  logic              prio_nx;
  logic [BW-1:0]     beat_cnt;
  logic [IW-1:0]     idle_cnt;
  logic              own0;
  logic              own1;
  logic              owned;
  logic              own_req;
  logic              own_valid;
  logic              acc;
  logic              acc_last;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              beat_max;
  logic              idle_max;
  logic              ovr_nx;
  logic              tmo_nx;
  logic              done;
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic [DATA_W-1:0] wrdata;
  logic              err_ovr;
  logic              err_tmo;

  // Owner channel select and burst-end detection
  always_comb begin
    own0      = (state == OWN0);
    own1      = (state == OWN1);
    owned     = own0 | own1;
    own_req   = own0 ? bus.iREQ0   : bus.iREQ1;
    own_valid = own0 ? bus.iVALID0 : bus.iVALID1;
    acc_last  = own0 ? bus.iLAST0  : bus.iLAST1;
    acc_addr  = own0 ? bus.iADDR0  : bus.iADDR1;
    acc_data  = own0 ? bus.iDATA0  : bus.iDATA1;
    acc       = owned & own_valid;
    beat_max  = acc & (beat_cnt == BEAT_LAST);
    idle_max  = owned & ~own_valid & (idle_cnt >= IDLE_LAST);
    ovr_nx    = beat_max & ~acc_last;
    tmo_nx    = idle_max & own_req;
    done      = owned & ((acc & acc_last) | beat_max
                | ~own_req | idle_max);
  end

  // Next state: grant from IDLE, return to IDLE at burst end
  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    unique case (state)
      IDLE: begin
        if (bus.iREQ0 & bus.iREQ1)
          state_nx = prio ? OWN1 : OWN0;
        else if (bus.iREQ0)
          state_nx = OWN0;
        else if (bus.iREQ1)
          state_nx = OWN1;
      end
      OWN0, OWN1: begin
        if (done) begin
          state_nx = IDLE;
          prio_nx  = own0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, round-robin pointer and one-cycle error pulses
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      prio    <= 1'b0;
      err_ovr <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      state   <= state_nx;
      prio    <= prio_nx;
      err_ovr <= ovr_nx;
      err_tmo <= tmo_nx;
    end
  end

  // Beat and idle counters, held clear outside a grant
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (!owned) begin
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (acc) begin
      beat_cnt <= beat_cnt + 1'b1;
      idle_cnt <= '0;
    end else if (~&idle_cnt) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Registered DMEM write port; addr/data hold between writes
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wren   <= 1'b0;
      wraddr <= '0;
      wrdata <= '0;
    end else begin
      wren <= acc;
      if (acc) begin
        wraddr <= acc_addr;
        wrdata <= acc_data;
      end
    end
  end

  assign bus.oGNT0        = own0;
  assign bus.oGNT1        = own1;
  assign bus.oREADY0      = own0;
  assign bus.oREADY1      = own1;
  assign bus.oBUSY        = (state != IDLE);
  assign bus.oWREN        = wren;
  assign bus.oWRADDR      = wraddr;
  assign bus.oWRDATA      = wrdata;
  assign bus.oERR_OVERRUN = err_ovr;
  assign bus.oERR_TIMEOUT = err_tmo;

endmodule
